// File: rtl/register_file_mp.sv
// register_file_mp: multi-port integer register file with two write lanes,
// optional write-to-read bypass, busy scoreboard and a handshaked debug scan.
`default_nettype none

module register_file_mp #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int NUM_READ   = 2,
  parameter int BYPASS     = 1
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [NUM_READ*ADDR_WIDTH-1:0]   rd_addr_i,
  output logic [NUM_READ*DATA_WIDTH-1:0]   rd_data_o,
  output logic [NUM_READ-1:0]              rd_busy_o,
  input  logic                             w0_en_i,
  input  logic [ADDR_WIDTH-1:0]            w0_addr_i,
  input  logic [DATA_WIDTH-1:0]            w0_data_i,
  input  logic                             w1_en_i,
  input  logic [ADDR_WIDTH-1:0]            w1_addr_i,
  input  logic [DATA_WIDTH-1:0]            w1_data_i,
  input  logic                             sb_set_en_i,
  input  logic [ADDR_WIDTH-1:0]            sb_set_addr_i,
  input  logic                             dbg_start_i,
  input  logic                             dbg_ready_i,
  output logic                             dbg_valid_o,
  output logic [ADDR_WIDTH-1:0]            dbg_addr_o,
  output logic [DATA_WIDTH-1:0]            dbg_data_o,
  output logic                             dbg_busy_o,
  output logic                             dbg_done_o
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_SCAN = 1'b1;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DEPTH-1:0]      busy_q, busy_d;

  logic w0_act, w1_act;
  assign w0_act = w0_en_i && (w0_addr_i != '0);
  assign w1_act = w1_en_i && (w1_addr_i != '0);

  // Lane 1 is assigned last so it wins a same-address conflict.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (w0_act) mem_q[w0_addr_i] <= w0_data_i;
      if (w1_act) mem_q[w1_addr_i] <= w1_data_i;
    end
  end

  always_comb begin
    busy_d = busy_q;
    if (w0_act) busy_d[w0_addr_i] = 1'b0;
    if (w1_act) busy_d[w1_addr_i] = 1'b0;
    if (sb_set_en_i) busy_d[sb_set_addr_i] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy_q <= '0;
    else        busy_q <= busy_d;
  end

  for (genvar p = 0; p < NUM_READ; p++) begin : g_rd
    logic [ADDR_WIDTH-1:0] rd_a;
    logic [DATA_WIDTH-1:0] rd_d;
    logic                  rd_b;

    assign rd_a = rd_addr_i[p*ADDR_WIDTH +: ADDR_WIDTH];

    always_comb begin
      rd_d = mem_q[rd_a];
      rd_b = busy_q[rd_a];
      if (BYPASS != 0) begin
        if (w0_act && (w0_addr_i == rd_a)) begin
          rd_d = w0_data_i;
          rd_b = 1'b0;
        end
        if (w1_act && (w1_addr_i == rd_a)) begin
          rd_d = w1_data_i;
          rd_b = 1'b0;
        end
      end
    end

    assign rd_data_o[p*DATA_WIDTH +: DATA_WIDTH] = rd_d;
    assign rd_busy_o[p]                          = rd_b;
  end

  logic [0:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] idx_q, idx_d, idx_nxt;
  logic [DATA_WIDTH-1:0] dbg_data_q, dbg_data_d, cap_data;
  logic                  valid_q, valid_d;
  logic                  done_q, done_d;

  assign idx_nxt = idx_q + 1'b1;

  // Capture sees this edge's writes so the scanned value matches post-edge contents.
  always_comb begin
    cap_data = mem_q[idx_nxt];
    if (w0_act && (w0_addr_i == idx_nxt)) cap_data = w0_data_i;
    if (w1_act && (w1_addr_i == idx_nxt)) cap_data = w1_data_i;
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    dbg_data_d = dbg_data_q;
    valid_d    = valid_q;
    done_d     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (dbg_start_i) begin
          state_d    = ST_SCAN;
          idx_d      = '0;
          dbg_data_d = '0;
          valid_d    = 1'b1;
        end
      end
      ST_SCAN: begin
        if (valid_q && dbg_ready_i) begin
          if (idx_q == '1) begin
            state_d = ST_IDLE;
            valid_d = 1'b0;
            done_d  = 1'b1;
          end else begin
            idx_d      = idx_nxt;
            dbg_data_d = cap_data;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      dbg_data_q <= '0;
      valid_q    <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      dbg_data_q <= dbg_data_d;
      valid_q    <= valid_d;
      done_q     <= done_d;
    end
  end

  assign dbg_valid_o = valid_q;
  assign dbg_addr_o  = idx_q;
  assign dbg_data_o  = dbg_data_q;
  assign dbg_busy_o  = (state_q == ST_SCAN);
  assign dbg_done_o  = done_q;

endmodule

`default_nettype wire

// File: tb/tb_register_file_mp.sv
// tb_register_file_mp: bypass and non-bypass builds driven in parallel and
// checked against an array-based reference model.
`default_nettype none

module tb_register_file_mp;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 2;
  localparam int DEPTH = 32;

  logic clk, rst_n;
  logic [NR*AW-1:0] rd_addr;
  logic [NR*DW-1:0] rd_data_b, rd_data_n;
  logic [NR-1:0]    rd_busy_b, rd_busy_n;
  logic             w0_en, w1_en, sb_set_en, dbg_start, dbg_ready;
  logic [AW-1:0]    w0_addr, w1_addr, sb_set_addr;
  logic [DW-1:0]    w0_data, w1_data;
  logic             dv_b, dv_n, dbz_b, dbz_n, dd_b, dd_n;
  logic [AW-1:0]    da_b, da_n;
  logic [DW-1:0]    ddat_b, ddat_n;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] m_mem [DEPTH];
  bit            m_busy [DEPTH];
  bit            s_active, s_done;
  int            s_idx;
  logic [DW-1:0] s_data;

  register_file_mp #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_READ(NR), .BYPASS(1)) u_byp (
    .clk(clk), .rst_n(rst_n), .rd_addr_i(rd_addr), .rd_data_o(rd_data_b), .rd_busy_o(rd_busy_b),
    .w0_en_i(w0_en), .w0_addr_i(w0_addr), .w0_data_i(w0_data),
    .w1_en_i(w1_en), .w1_addr_i(w1_addr), .w1_data_i(w1_data),
    .sb_set_en_i(sb_set_en), .sb_set_addr_i(sb_set_addr),
    .dbg_start_i(dbg_start), .dbg_ready_i(dbg_ready), .dbg_valid_o(dv_b), .dbg_addr_o(da_b),
    .dbg_data_o(ddat_b), .dbg_busy_o(dbz_b), .dbg_done_o(dd_b));

  register_file_mp #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_READ(NR), .BYPASS(0)) u_nob (
    .clk(clk), .rst_n(rst_n), .rd_addr_i(rd_addr), .rd_data_o(rd_data_n), .rd_busy_o(rd_busy_n),
    .w0_en_i(w0_en), .w0_addr_i(w0_addr), .w0_data_i(w0_data),
    .w1_en_i(w1_en), .w1_addr_i(w1_addr), .w1_data_i(w1_data),
    .sb_set_en_i(sb_set_en), .sb_set_addr_i(sb_set_addr),
    .dbg_start_i(dbg_start), .dbg_ready_i(dbg_ready), .dbg_valid_o(dv_n), .dbg_addr_o(da_n),
    .dbg_data_o(ddat_n), .dbg_busy_o(dbz_n), .dbg_done_o(dd_n));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic void model_reset();
    for (int i = 0; i < DEPTH; i++) begin
      m_mem[i] = '0;
      m_busy[i] = 1'b0;
    end
    s_active = 1'b0; s_done = 1'b0; s_idx = 0; s_data = '0;
  endfunction

  // Register-file semantics applied at one rising edge with the current inputs.
  function automatic void model_step();
    bit acc, st;
    acc = s_active && dbg_ready;
    st  = !s_active && dbg_start;
    if (w0_en && w0_addr != 0) m_mem[w0_addr] = w0_data;
    if (w1_en && w1_addr != 0) m_mem[w1_addr] = w1_data;
    if (w0_en && w0_addr != 0) m_busy[w0_addr] = 1'b0;
    if (w1_en && w1_addr != 0) m_busy[w1_addr] = 1'b0;
    if (sb_set_en && sb_set_addr != 0) m_busy[sb_set_addr] = 1'b1;
    s_done = 1'b0;
    if (st) begin
      s_active = 1'b1; s_idx = 0; s_data = '0;
    end else if (acc) begin
      if (s_idx == DEPTH - 1) begin
        s_active = 1'b0; s_done = 1'b1;
      end else begin
        s_idx = s_idx + 1;
        s_data = m_mem[s_idx];
      end
    end
  endfunction

  function automatic logic [DW-1:0] exp_data(int a, bit byp);
    if (byp && w1_en && a != 0 && int'(w1_addr) == a) return w1_data;
    if (byp && w0_en && a != 0 && int'(w0_addr) == a) return w0_data;
    return m_mem[a];
  endfunction

  function automatic bit exp_busy(int a, bit byp);
    if (byp && w1_en && a != 0 && int'(w1_addr) == a) return 1'b0;
    if (byp && w0_en && a != 0 && int'(w0_addr) == a) return 1'b0;
    return m_busy[a];
  endfunction

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic idle_inputs();
    w0_en = 0; w1_en = 0; sb_set_en = 0; dbg_start = 0; dbg_ready = 0;
    w0_addr = 0; w1_addr = 0; w0_data = 0; w1_data = 0; sb_set_addr = 0;
  endtask

  task automatic test_reset();
    for (int i = 1; i <= 4; i++) begin
      w0_en = 1; w0_addr = AW'(i); w0_data = $urandom;
      sb_set_en = 1; sb_set_addr = AW'(i + 8);
      tick();
    end
    idle_inputs();
    dbg_start = 1; dbg_ready = 1;
    tick();
    tick();
    idle_inputs();
    rd_addr = {AW'(9), AW'(2)};
    #2 rst_n = 0;
    #1;
    model_reset();
    checks++;
    if (rd_data_b !== '0 || rd_data_n !== '0 || rd_busy_b !== '0 || rd_busy_n !== '0) begin
      errors++;
      $display("FAIL reset_reads: data_b=%h data_n=%h busy_b=%b busy_n=%b required all 0",
               rd_data_b, rd_data_n, rd_busy_b, rd_busy_n);
    end
    checks++;
    if ({dv_b, dbz_b, dd_b, dv_n, dbz_n, dd_n} !== 6'b0 || da_b !== '0 || ddat_b !== '0) begin
      errors++;
      $display("FAIL reset_dbg: valid=%b busy=%b done=%b addr=%0d data=%h required 0",
               dv_b, dbz_b, dd_b, da_b, ddat_b);
    end
    #2 rst_n = 1;
    tick();
    checks++;
    if (rd_data_b !== '0 || rd_busy_b !== '0 || dv_b !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: data=%h busy=%b valid=%b required 0", rd_data_b, rd_busy_b, dv_b);
    end
  endtask

  task automatic test_write_conflict();
    w0_en = 1; w0_addr = 5; w0_data = 32'hAAAA_0000;
    w1_en = 1; w1_addr = 5; w1_data = 32'h1234_5678;
    rd_addr = {AW'(0), AW'(5)};
    #1;
    checks++;
    if (rd_data_b[31:0] !== 32'h1234_5678 || rd_data_n[31:0] !== m_mem[5]) begin
      errors++;
      $display("FAIL conflict_same_cycle: byp=%h nob=%h required %h / %h",
               rd_data_b[31:0], rd_data_n[31:0], 32'h1234_5678, m_mem[5]);
    end
    tick();
    idle_inputs();
    #1;
    checks++;
    if (rd_data_b[31:0] !== 32'h1234_5678 || rd_data_n[31:0] !== 32'h1234_5678) begin
      errors++;
      $display("FAIL conflict_lane1_wins: byp=%h nob=%h required 12345678",
               rd_data_b[31:0], rd_data_n[31:0]);
    end
    w0_en = 1; w0_addr = 0; w0_data = 32'hFFFF_FFFF;
    w1_en = 1; w1_addr = 0; w1_data = 32'h5555_5555;
    sb_set_en = 1; sb_set_addr = 0;
    #1;
    checks++;
    if (rd_data_b[63:32] !== '0 || rd_data_n[63:32] !== '0) begin
      errors++;
      $display("FAIL x0_bypass: byp=%h nob=%h required 0", rd_data_b[63:32], rd_data_n[63:32]);
    end
    tick();
    idle_inputs();
    #1;
    checks++;
    if (rd_data_b[63:32] !== '0 || rd_data_n[63:32] !== '0 || rd_busy_b[1] !== 1'b0) begin
      errors++;
      $display("FAIL x0_write: byp=%h nob=%h busy=%b required 0", rd_data_b[63:32],
               rd_data_n[63:32], rd_busy_b[1]);
    end
  endtask

  task automatic test_bypass();
    logic [DW-1:0] old;
    old = m_mem[7];
    w0_en = 1; w0_addr = 7; w0_data = 32'hDEAD_BEEF;
    rd_addr = {AW'(7), AW'(7)};
    #1;
    checks++;
    if (rd_data_b[31:0] !== 32'hDEAD_BEEF || rd_data_b[63:32] !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL bypass_same_cycle: got %h required deadbeef", rd_data_b[31:0]);
    end
    checks++;
    if (rd_data_n[31:0] !== old) begin
      errors++;
      $display("FAIL nobypass_same_cycle: got %h required %h", rd_data_n[31:0], old);
    end
    tick();
    idle_inputs();
    #1;
    checks++;
    if (rd_data_n[31:0] !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL nobypass_next_cycle: got %h required deadbeef", rd_data_n[31:0]);
    end
  endtask

  task automatic test_scoreboard();
    sb_set_en = 1; sb_set_addr = 3;
    rd_addr = {AW'(3), AW'(3)};
    tick();
    idle_inputs();
    #1;
    checks++;
    if (rd_busy_b !== 2'b11 || rd_busy_n !== 2'b11) begin
      errors++;
      $display("FAIL sb_set: byp=%b nob=%b required 11", rd_busy_b, rd_busy_n);
    end
    w1_en = 1; w1_addr = 3; w1_data = 32'h0000_0333;
    sb_set_en = 1; sb_set_addr = 3;
    #1;
    checks++;
    if (rd_busy_b !== 2'b00 || rd_busy_n !== 2'b11) begin
      errors++;
      $display("FAIL sb_bypass_mask: byp=%b nob=%b required 00 / 11", rd_busy_b, rd_busy_n);
    end
    tick();
    idle_inputs();
    #1;
    checks++;
    if (rd_busy_b !== 2'b11 || rd_busy_n !== 2'b11) begin
      errors++;
      $display("FAIL sb_set_wins: byp=%b nob=%b required 11", rd_busy_b, rd_busy_n);
    end
    w0_en = 1; w0_addr = 3; w0_data = 32'h0000_0444;
    tick();
    idle_inputs();
    #1;
    checks++;
    if (rd_busy_b !== 2'b00 || rd_busy_n !== 2'b00) begin
      errors++;
      $display("FAIL sb_clear: byp=%b nob=%b required 00", rd_busy_b, rd_busy_n);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 300; c++) begin
      w0_en = 1'($urandom); w0_addr = AW'($urandom_range(0, 7)); w0_data = $urandom;
      w1_en = 1'($urandom); w1_addr = AW'($urandom_range(0, 7)); w1_data = $urandom;
      sb_set_en = 1'($urandom); sb_set_addr = AW'($urandom_range(0, 7));
      if (c % 50 == 49) begin
        w0_addr = AW'($urandom_range(8, 31)); w1_addr = w0_addr;
      end
      for (int p = 0; p < NR; p++) rd_addr[p*AW +: AW] = AW'($urandom_range(0, 9));
      #1;
      for (int p = 0; p < NR; p++) begin
        int a;
        a = int'(rd_addr[p*AW +: AW]);
        checks++;
        if (rd_data_b[p*DW +: DW] !== exp_data(a, 1) || rd_busy_b[p] !== exp_busy(a, 1)) begin
          errors++;
          $display("FAIL rand_byp c=%0d p=%0d a=%0d: data=%h busy=%b required %h %b", c, p, a,
                   rd_data_b[p*DW +: DW], rd_busy_b[p], exp_data(a, 1), exp_busy(a, 1));
        end
        checks++;
        if (rd_data_n[p*DW +: DW] !== exp_data(a, 0) || rd_busy_n[p] !== exp_busy(a, 0)) begin
          errors++;
          $display("FAIL rand_nob c=%0d p=%0d a=%0d: data=%h busy=%b required %h %b", c, p, a,
                   rd_data_n[p*DW +: DW], rd_busy_n[p], exp_data(a, 0), exp_busy(a, 0));
        end
      end
      tick();
    end
    idle_inputs();
  endtask

  task automatic test_scan();
    logic [DW-1:0] seen [DEPTH];
    int  done_cnt, accepts;
    bit  finished;
    w0_en = 1; w0_addr = 1;  w0_data = 32'h11;
    w1_en = 1; w1_addr = 31; w1_data = 32'hFF;
    tick();
    idle_inputs();
    dbg_start = 1;
    tick();
    dbg_start = 0;
    done_cnt = 0; accepts = 0; finished = 0;
    for (int c = 0; c < 200 && !finished; c++) begin
      checks++;
      if (dv_b !== s_active || dbz_b !== s_active || dd_b !== s_done ||
          dv_n !== s_active || dd_n !== s_done) begin
        errors++;
        $display("FAIL scan_ctrl c=%0d: valid=%b busy=%b done=%b required %b %b %b",
                 c, dv_b, dbz_b, dd_b, s_active, s_active, s_done);
      end
      if (s_active) begin
        checks++;
        if (int'(da_b) != s_idx || ddat_b !== s_data || ddat_n !== s_data) begin
          errors++;
          $display("FAIL scan_entry c=%0d: addr=%0d data=%h required %0d %h",
                   c, da_b, ddat_b, s_idx, s_data);
        end
      end
      if (s_done) begin
        done_cnt++;
        finished = 1;
      end
      idle_inputs();
      dbg_ready = (c % 2 == 1);
      dbg_start = (c == 6);
      if (s_active && dbg_ready) begin
        seen[s_idx] = ddat_b;
        accepts++;
      end
      if (s_active && !dbg_ready && s_idx != 0) begin
        w0_en = 1; w0_addr = AW'(s_idx); w0_data = $urandom;
      end
      if (!finished) tick();
    end
    idle_inputs();
    tick();
    checks++;
    if (done_cnt != 1 || accepts != DEPTH || dd_b !== 1'b0) begin
      errors++;
      $display("FAIL scan_done_once: done_pulses=%0d accepts=%0d done_now=%b required 1 32 0",
               done_cnt, accepts, dd_b);
    end
    checks++;
    if (seen[0] !== 32'h0 || seen[1] !== 32'h11 || seen[31] !== 32'hFF) begin
      errors++;
      $display("FAIL scan_values: x0=%h x1=%h x31=%h required 0 11 ff", seen[0], seen[1], seen[31]);
    end
  endtask

  task automatic test_back_to_back();
    int  cyc;
    dbg_ready = 1; dbg_start = 1;
    tick();
    dbg_start = 0;
    cyc = 0;
    while (!s_done && cyc < 100) begin
      tick();
      cyc++;
    end
    checks++;
    if (!s_done || dd_b !== 1'b1 || cyc != DEPTH) begin
      errors++;
      $display("FAIL b2b_latency: done=%b after %0d cycles required 1 after %0d", dd_b, cyc, DEPTH);
    end
    dbg_start = 1;
    tick();
    dbg_start = 0;
    checks++;
    if (dv_b !== 1'b1 || dbz_b !== 1'b1 || da_b !== '0 || ddat_b !== '0 || dd_b !== 1'b0) begin
      errors++;
      $display("FAIL b2b_restart: valid=%b busy=%b addr=%0d data=%h done=%b required 1 1 0 0 0",
               dv_b, dbz_b, da_b, ddat_b, dd_b);
    end
  endtask

  task automatic test_reset_mid_scan();
    int cyc;
    dbg_ready = 1; dbg_start = 1;
    cyc = 0;
    while (!(s_active && s_idx == 10) && cyc < 100) begin
      tick();
      dbg_start = 0;
      cyc++;
    end
    checks++;
    if (int'(da_b) != 10 || dv_b !== 1'b1) begin
      errors++;
      $display("FAIL midscan_reach: addr=%0d valid=%b required 10 1", da_b, dv_b);
    end
    idle_inputs();
    #2 rst_n = 0;
    #1;
    model_reset();
    checks++;
    if (dv_b !== 1'b0 || dbz_b !== 1'b0 || dd_b !== 1'b0 || da_b !== '0) begin
      errors++;
      $display("FAIL midscan_abort: valid=%b busy=%b done=%b addr=%0d required 0",
               dv_b, dbz_b, dd_b, da_b);
    end
    #2 rst_n = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (dd_b !== 1'b0 || dv_b !== 1'b0 || dbz_b !== 1'b0) begin
        errors++;
        $display("FAIL midscan_no_done: done=%b valid=%b busy=%b required 0", dd_b, dv_b, dbz_b);
      end
    end
    dbg_start = 1;
    tick();
    dbg_start = 0;
    checks++;
    if (dv_b !== 1'b1 || da_b !== '0 || ddat_b !== '0) begin
      errors++;
      $display("FAIL midscan_restart: valid=%b addr=%0d data=%h required 1 0 0", dv_b, da_b, ddat_b);
    end
  endtask

  initial begin
    rst_n = 0;
    rd_addr = '0;
    idle_inputs();
    model_reset();
    #12 rst_n = 1;
    tick();
    test_reset();
    test_write_conflict();
    test_bypass();
    test_scoreboard();
    test_random();
    test_scan();
    test_back_to_back();
    test_reset_mid_scan();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
